// File: rtl/branch_recovery_pkg.sv
// Shared types and constants for the branch recovery controller.
//   b_data        : registered branch-unit result bundle
//   recov_state_t : recovery FSM states
//   ROB_DEPTH / ROB_TAG_W / ROB_IDX_W : reorder-buffer geometry
package branch_recovery_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_TAG_W = 5;
  localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic                 fu_b_done;
    logic                 jalr_bne_signal;
    logic                 mispredict;
    logic [ROB_TAG_W-1:0] mispredict_tag;
    logic [31:0]          pc;
    logic [31:0]          data;
    logic [5:0]           p_b;
    logic [ROB_TAG_W-1:0] rob_fu_b;
  } b_data;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BROADCAST = 2'd1,
    WAIT_ROB  = 2'd2,
    REDIRECT  = 2'd3
  } recov_state_t;

endpackage

// File: rtl/branch_recovery_age_cmp.sv
// Combinational ROB age comparator.
//   tag_a, tag_b : ROB tags to compare
//   head         : current ROB head (oldest entry)
//   a_older      : 1 when tag_a is strictly older than tag_b
// Age is the distance from the head modulo the ROB depth.
module rob_age_cmp
  import branch_recovery_pkg::*;
(
  input  logic [ROB_TAG_W-1:0] tag_a,
  input  logic [ROB_TAG_W-1:0] tag_b,
  input  logic [ROB_TAG_W-1:0] head,
  output logic                 a_older
);

  logic [ROB_IDX_W-1:0] age_a;
  logic [ROB_IDX_W-1:0] age_b;
  logic                 unused_tag_msbs;

  // Index-width subtraction gives the modulo-depth wrap for free.
  assign age_a   = tag_a[ROB_IDX_W-1:0] - head[ROB_IDX_W-1:0];
  assign age_b   = tag_b[ROB_IDX_W-1:0] - head[ROB_IDX_W-1:0];
  assign a_older = (age_a < age_b);

  assign unused_tag_msbs = ^{tag_a[ROB_TAG_W-1:ROB_IDX_W],
                             tag_b[ROB_TAG_W-1:ROB_IDX_W],
                             head[ROB_TAG_W-1:ROB_IDX_W]};

endmodule

// File: rtl/branch_recovery.sv
// Branch misprediction / jump recovery controller.
//   clk, reset        : clock, synchronous active-high reset
//   b_in              : branch-unit result bundle
//   rob_head          : ROB head tag
//   rob_recover_done  : ROB/rename rollback complete pulse
//   redirect_ready    : fetch accepts redirect
//   mispredict, mispredict_tag : rollback broadcast
//   flush             : front-end flush pulse
//   redirect_valid, redirect_pc : fetch redirect request
//   recovery_busy     : stall rename/dispatch
//   redirect_count    : completed redirects (wrapping)
// All outputs are registered from the next-state values.
module branch_recovery
  import branch_recovery_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  b_data                b_in,
  input  logic [ROB_TAG_W-1:0] rob_head,
  input  logic                 rob_recover_done,
  input  logic                 redirect_ready,
  output logic                 mispredict,
  output logic [ROB_TAG_W-1:0] mispredict_tag,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 recovery_busy,
  output logic [15:0]          redirect_count
);

  recov_state_t         state_q, state_n;
  logic [ROB_TAG_W-1:0] tag_q, tag_n;
  logic [31:0]          pc_q, pc_n;
  logic                 flush_n;
  logic                 count_inc;

  logic                 evt, mp_evt;
  logic [ROB_TAG_W-1:0] evt_tag;
  logic                 evt_older;
  logic                 take_evt;
  logic                 unused_b_fields;

  assign evt     = b_in.fu_b_done && b_in.jalr_bne_signal;
  assign mp_evt  = evt && b_in.mispredict;
  // A jump has no mispredict tag of its own; its ROB slot orders it.
  assign evt_tag = b_in.mispredict ? b_in.mispredict_tag : b_in.rob_fu_b;

  assign unused_b_fields = ^{b_in.data, b_in.p_b};

  rob_age_cmp u_age_cmp (
    .tag_a   (evt_tag),
    .tag_b   (tag_q),
    .head    (rob_head),
    .a_older (evt_older)
  );

  always_comb begin
    state_n   = state_q;
    tag_n     = tag_q;
    pc_n      = pc_q;
    flush_n   = 1'b0;
    count_inc = 1'b0;

    // In IDLE any event starts a recovery; otherwise only a strictly
    // older one preempts, and it takes priority over every exit condition.
    take_evt = (state_q == IDLE) ? evt : (evt && evt_older);

    if (take_evt) begin
      tag_n   = evt_tag;
      pc_n    = b_in.pc;
      flush_n = 1'b1;
      state_n = mp_evt ? BROADCAST : REDIRECT;
    end else begin
      case (state_q)
        IDLE:      state_n = IDLE;
        BROADCAST: state_n = WAIT_ROB;
        WAIT_ROB:  if (rob_recover_done) state_n = REDIRECT;
        REDIRECT: begin
          if (redirect_ready) begin
            state_n   = IDLE;
            count_inc = 1'b1;
          end
        end
        default:   state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      tag_q          <= '0;
      pc_q           <= '0;
      mispredict     <= 1'b0;
      mispredict_tag <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      recovery_busy  <= 1'b0;
      redirect_count <= '0;
    end else begin
      state_q        <= state_n;
      tag_q          <= tag_n;
      pc_q           <= pc_n;
      mispredict     <= (state_n == BROADCAST);
      mispredict_tag <= (state_n == BROADCAST) ? tag_n : '0;
      flush          <= flush_n;
      redirect_valid <= (state_n == REDIRECT);
      redirect_pc    <= (state_n == REDIRECT) ? pc_n : '0;
      recovery_busy  <= (state_n != IDLE);
      if (count_inc) redirect_count <= redirect_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_recovery.sv
module tb_branch_recovery;
  import branch_recovery_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  b_data       b_in;
  logic [4:0]  rob_head;
  logic        rob_recover_done;
  logic        redirect_ready;
  logic        mispredict;
  logic [4:0]  mispredict_tag;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        recovery_busy;
  logic [15:0] redirect_count;

  int n_cmp = 0;
  int n_bad = 0;

  branch_recovery dut (
    .clk              (clk),
    .reset            (reset),
    .b_in             (b_in),
    .rob_head         (rob_head),
    .rob_recover_done (rob_recover_done),
    .redirect_ready   (redirect_ready),
    .mispredict       (mispredict),
    .mispredict_tag   (mispredict_tag),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .recovery_busy    (recovery_busy),
    .redirect_count   (redirect_count)
  );

  always #5 clk = ~clk;

  // Reference model: one pending recovery, described by its kind and the
  // phase it is in (0 = announcing rollback, 1 = awaiting ROB, 2 = asking fetch).
  bit         m_active;
  int         m_phase;
  logic [4:0] m_tag;
  logic [31:0] m_pc;
  bit         m_flush;
  int         m_count;

  function automatic int age(input logic [4:0] t, input logic [4:0] h);
    return ((int'(t) % 16) - (int'(h) % 16) + 16) % 16;
  endfunction

  task automatic model_update();
    bit         ev;
    logic [4:0] ntag;
    m_flush = 0;
    if (reset) begin
      m_active = 0; m_phase = 0; m_tag = 0; m_pc = 0; m_count = 0;
      return;
    end
    ev   = b_in.fu_b_done && b_in.jalr_bne_signal;
    ntag = b_in.mispredict ? b_in.mispredict_tag : b_in.rob_fu_b;
    if (ev && (!m_active || age(ntag, rob_head) < age(m_tag, rob_head))) begin
      m_active = 1;
      m_tag    = ntag;
      m_pc     = b_in.pc;
      m_phase  = b_in.mispredict ? 0 : 2;
      m_flush  = 1;
    end else if (m_active) begin
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (rob_recover_done) m_phase = 2;
      end else if (redirect_ready) begin
        m_active = 0;
        m_count  = (m_count + 1) % 65536;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    bit bc, rv;
    bc = m_active && (m_phase == 0);
    rv = m_active && (m_phase == 2);
    chk("mispredict",     32'(mispredict),     32'(bc));
    chk("mispredict_tag", 32'(mispredict_tag), bc ? 32'(m_tag) : 32'd0);
    chk("flush",          32'(flush),          32'(m_flush));
    chk("redirect_valid", 32'(redirect_valid), 32'(rv));
    chk("redirect_pc",    redirect_pc,         rv ? m_pc : 32'd0);
    chk("recovery_busy",  32'(recovery_busy),  32'(m_active));
    chk("redirect_count", 32'(redirect_count), 32'(m_count));
  endtask

  task automatic step(input bit do_chk);
    @(posedge clk);
    model_update();
    #1;
    if (do_chk) check_all();
  endtask

  task automatic clear_in();
    b_in             = '0;
    rob_recover_done = 1'b0;
    redirect_ready   = 1'b0;
  endtask

  task automatic set_evt(input bit mp, input logic [4:0] tag, input logic [31:0] pc);
    b_in.fu_b_done       = 1'b1;
    b_in.jalr_bne_signal = 1'b1;
    b_in.mispredict      = mp;
    b_in.mispredict_tag  = mp ? tag : 5'd0;
    b_in.rob_fu_b        = tag;
    b_in.pc              = pc;
  endtask

  initial begin
    reset = 1'b1; rob_head = '0; clear_in();
    step(1);
    chk("reset_busy", 32'(recovery_busy), 32'd0);
    reset = 1'b0;
    step(1);

    // bne mispredict, tag 3, pc 0x40, head 0
    set_evt(1, 5'd3, 32'h40);
    step(1);
    chk("bne_mispredict", 32'(mispredict), 32'd1);
    chk("bne_flush", 32'(flush), 32'd1);
    chk("bne_tag", 32'(mispredict_tag), 32'd3);
    clear_in();
    step(1); step(1); step(1);
    chk("bne_wait_no_redirect", 32'(redirect_valid), 32'd0);
    rob_recover_done = 1'b1;
    step(1);
    rob_recover_done = 1'b0;
    chk("bne_redirect_pc", redirect_pc, 32'h40);
    step(1); step(1);
    redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;
    chk("bne_count", 32'(redirect_count), 32'd1);
    chk("bne_idle", 32'(recovery_busy), 32'd0);

    // jalr jump, pc 0x100, fetch stalls three cycles
    set_evt(0, 5'd4, 32'h100);
    step(1);
    chk("jalr_flush", 32'(flush), 32'd1);
    chk("jalr_pc", redirect_pc, 32'h100);
    clear_in();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) redirect_ready = 1'b1;
      step(1);
      if (i < 2) begin
        chk("jalr_pc_hold", redirect_pc, 32'h100);
        chk("jalr_no_reflush", 32'(flush), 32'd0);
      end
    end
    redirect_ready = 1'b0;
    chk("jalr_idle", 32'(redirect_valid), 32'd0);
    chk("jalr_count", 32'(redirect_count), 32'd2);

    // preemption around a wrapped head
    rob_head = 5'd14;
    set_evt(1, 5'd1, 32'h200);
    step(1); clear_in(); step(1);
    set_evt(1, 5'd2, 32'h300);
    step(1);
    chk("younger_dropped", 32'(mispredict), 32'd0);
    set_evt(1, 5'd15, 32'h400);
    step(1);
    chk("preempt_broadcast", 32'(mispredict), 32'd1);
    chk("preempt_tag", 32'(mispredict_tag), 32'd15);
    clear_in();
    step(1);
    rob_recover_done = 1'b1; step(1); rob_recover_done = 1'b0;
    chk("preempt_pc", redirect_pc, 32'h400);
    redirect_ready = 1'b1; step(1); redirect_ready = 1'b0;

    // reset in WAIT_ROB with coincident event and done pulse
    rob_head = 5'd0;
    set_evt(1, 5'd5, 32'h500);
    step(1); clear_in(); step(1);
    reset = 1'b1;
    set_evt(1, 5'd1, 32'h600);
    rob_recover_done = 1'b1;
    step(1);
    chk("rst_busy", 32'(recovery_busy), 32'd0);
    chk("rst_count", 32'(redirect_count), 32'd0);
    reset = 1'b0; clear_in();
    rob_recover_done = 1'b1; step(1); rob_recover_done = 1'b0;
    step(1);
    chk("rst_no_resume", 32'(redirect_valid), 32'd0);

    // preemption coincident with redirect_ready
    set_evt(0, 5'd8, 32'h700);
    step(1); clear_in();
    set_evt(1, 5'd2, 32'h800);
    redirect_ready = 1'b1;
    step(1);
    clear_in();
    chk("coinc_no_inc", 32'(redirect_count), 32'd0);
    chk("coinc_broadcast", 32'(mispredict), 32'd1);
    step(1);
    rob_recover_done = 1'b1; step(1); rob_recover_done = 1'b0;
    redirect_ready = 1'b1; step(1); redirect_ready = 1'b0;
    chk("coinc_inc_once", 32'(redirect_count), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset                = ($urandom_range(0, 63) == 0);
      b_in.fu_b_done       = ($urandom_range(0, 3) == 0);
      b_in.jalr_bne_signal = ($urandom_range(0, 3) != 0);
      b_in.mispredict      = 1'($urandom);
      b_in.mispredict_tag  = 5'($urandom);
      b_in.rob_fu_b        = 5'($urandom);
      b_in.pc              = $urandom;
      b_in.data            = $urandom;
      b_in.p_b             = 6'($urandom);
      rob_head             = 5'($urandom_range(0, 15));
      rob_recover_done     = ($urandom_range(0, 5) == 0);
      redirect_ready       = 1'($urandom);
      step(1);
    end

    // redirect_count wrap: a held jump completes one redirect per two cycles
    reset = 1'b1; clear_in(); rob_head = '0; step(1);
    reset = 1'b0;
    set_evt(0, 5'd6, 32'h900);
    redirect_ready = 1'b1;
    for (int i = 0; i < 131070; i++) step(0);
    check_all();
    chk("wrap_max", 32'(redirect_count), 32'hFFFF);
    step(1);
    step(1);
    chk("wrap_zero", 32'(redirect_count), 32'd0);
    clear_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
